axi_write_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a single AXI write channel (AW/W/B). It sits between two write masters and one write slave port. It grants one whole burst at a time in round-robin order. For each granted burst it issues the address phase, steers W beats and generates WLAST, then routes the B response back to the winning requester.

---
 rtl/axi_warb_pkg.sv | 16 +
 rtl/axi_write_arbiter_if.sv | 69 ++++++
 rtl/axi_write_arbiter_rr_arb2.sv | 15 +
 rtl/axi_write_arbiter.sv | 136 +++++++++++++
 tb/tb_axi_write_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_warb_pkg.sv
// axi_warb_pkg: shared types and constants for axi_write_arbiter.
//   warb_state_e    : sequencer state (IDLE -> ADDR -> DATA -> RESP)
//   BRESP_*         : AXI write response codes
//   TIMEOUT_CYCLES  : RESP watchdog limit (used with AXI_WARB_TIMEOUT_EN)
package axi_warb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } warb_state_e;

  localparam logic [1:0]  BRESP_OKAY     = 2'b00;
  localparam logic [1:0]  BRESP_SLVERR   = 2'b10;
  localparam int unsigned TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/axi_write_arbiter_if.sv
// axi_write_arbiter_if: requester-side and downstream AW/W/B signals.
//   Params : AW address width, DW data width (strobe = DW/8)
//   rq_*   : two requesters, requester i in packed slice [i]
//   m_*    : single downstream write slave
//   master : arbiter view (drives m_* requests and rq_* ready/resp)
//   slave  : environment view (the opposite directions)
interface axi_write_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [1:0]                rq_awvalid;
  logic [1:0]                rq_awready;
  logic [1:0][AW-1:0]        rq_awaddr;
  logic [1:0][7:0]           rq_awlen;
  logic [1:0][2:0]           rq_awsize;
  logic [1:0][1:0]           rq_awburst;
  logic [1:0]                rq_wvalid;
  logic [1:0]                rq_wready;
  logic [1:0][DW-1:0]        rq_wdata;
  logic [1:0][DW/8-1:0]      rq_wstrb;
  logic [1:0]                rq_bvalid;
  logic [1:0]                rq_bready;
  logic [1:0]                rq_bresp;

  logic                      m_awvalid;
  logic                      m_awready;
  logic [AW-1:0]             m_awaddr;
  logic [7:0]                m_awlen;
  logic [2:0]                m_awsize;
  logic [1:0]                m_awburst;
  logic                      m_wvalid;
  logic                      m_wready;
  logic [DW-1:0]             m_wdata;
  logic [DW/8-1:0]           m_wstrb;
  logic                      m_wlast;
  logic                      m_bvalid;
  logic                      m_bready;
  logic [1:0]                m_bresp;

  modport master (
    input  rq_awvalid, rq_awaddr, rq_awlen, rq_awsize, rq_awburst,
    output rq_awready,
    input  rq_wvalid, rq_wdata, rq_wstrb,
    output rq_wready,
    output rq_bvalid, rq_bresp,
    input  rq_bready,
    output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb, m_wlast,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready
  );

  modport slave (
    output rq_awvalid, rq_awaddr, rq_awlen, rq_awsize, rq_awburst,
    input  rq_awready,
    output rq_wvalid, rq_wdata, rq_wstrb,
    input  rq_wready,
    input  rq_bvalid, rq_bresp,
    output rq_bready,
    input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready
  );
endinterface

// File: rtl/axi_write_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin selector.
//   i_req        : request vector
//   i_last_grant : index of the requester granted last
//   o_gnt        : one-hot grant (zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = i_req;
    // on a tie the requester not granted last wins
    if (&i_req) o_gnt = i_last_grant ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: grants one whole AXI write burst at a time to one of
// two requesters (round-robin), issues AW, steers W with generated WLAST,
// and routes B back to the winner.
//   clk     : clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : axi_write_arbiter_if.master (rq_* requester side, m_* slave side)
//   timeout_o : one-cycle pulse after a watchdog-forced response
//               (present only when AXI_WARB_TIMEOUT_EN is defined)
// Build option AXI_WARB_TIMEOUT_EN: RESP watchdog that answers SLVERR when
// the slave stays silent for TIMEOUT_CYCLES cycles.
module axi_write_arbiter
  import axi_warb_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  axi_write_arbiter_if.master bus
`ifdef AXI_WARB_TIMEOUT_EN
  ,
  output logic timeout_o
`endif
);

  warb_state_e r_state, w_nstate;
  // Winner of the current burst; also serves as last_grant for the
  // arbiter since both always hold the same value.
  logic        r_grant;
  logic [7:0]  r_cnt;
  logic [1:0]  w_gnt;
  logic        w_gidx;
  logic        w_req_any;
  logic        w_whs;
  logic        w_tmo;

  rr_arb2 u_arb (
    .i_req        (bus.rq_awvalid),
    .i_last_grant (r_grant),
    .o_gnt        (w_gnt)
  );

  assign w_gidx    = w_gnt[1];
  assign w_req_any = |bus.rq_awvalid;
  assign w_whs     = bus.rq_wvalid[r_grant] & bus.m_wready;

`ifdef AXI_WARB_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_timeout;

  assign w_tmo     = (r_state == ST_RESP) && (r_wdog == 8'(TIMEOUT_CYCLES));
  assign timeout_o = r_timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo & bus.rq_bready[r_grant];
      if (r_state != ST_RESP)             r_wdog <= '0;
      else if (!bus.m_bvalid && !w_tmo)   r_wdog <= r_wdog + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_nstate       = r_state;
    bus.rq_awready = '0;
    bus.m_awvalid  = 1'b0;
    bus.m_wvalid   = 1'b0;
    bus.m_wdata    = '0;
    bus.m_wstrb    = '0;
    bus.m_wlast    = 1'b0;
    bus.rq_wready  = '0;
    bus.m_bready   = 1'b0;
    bus.rq_bvalid  = '0;
    bus.rq_bresp   = BRESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        // gated so every output reads 0 while reset is held
        bus.rq_awready = w_gnt & {2{resetn}};
        if (w_req_any) w_nstate = ST_ADDR;
      end
      ST_ADDR: begin
        bus.m_awvalid = 1'b1;
        if (bus.m_awready) w_nstate = ST_DATA;
      end
      ST_DATA: begin
        bus.m_wvalid           = bus.rq_wvalid[r_grant];
        bus.m_wdata            = bus.rq_wdata[r_grant];
        bus.m_wstrb            = bus.rq_wstrb[r_grant];
        bus.m_wlast            = (r_cnt == 8'd0);
        bus.rq_wready[r_grant] = bus.m_wready;
        if (w_whs && r_cnt == 8'd0) w_nstate = ST_RESP;
      end
      ST_RESP: begin
        if (w_tmo) begin
          // slave never answered: fabricate SLVERR, keep slave side quiet
          bus.rq_bvalid[r_grant] = 1'b1;
          bus.rq_bresp           = BRESP_SLVERR;
          if (bus.rq_bready[r_grant]) w_nstate = ST_IDLE;
        end else begin
          bus.m_bready           = bus.rq_bready[r_grant];
          bus.rq_bvalid[r_grant] = bus.m_bvalid;
          bus.rq_bresp           = bus.m_bresp;
          if (bus.m_bvalid && bus.rq_bready[r_grant]) w_nstate = ST_IDLE;
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_grant       <= 1'b1;
      r_cnt         <= '0;
      bus.m_awaddr  <= '0;
      bus.m_awlen   <= '0;
      bus.m_awsize  <= '0;
      bus.m_awburst <= '0;
    end else begin
      r_state <= w_nstate;
      if (r_state == ST_IDLE && w_req_any) begin
        r_grant       <= w_gidx;
        r_cnt         <= bus.rq_awlen[w_gidx];
        bus.m_awaddr  <= bus.rq_awaddr[w_gidx];
        bus.m_awlen   <= bus.rq_awlen[w_gidx];
        bus.m_awsize  <= bus.rq_awsize[w_gidx];
        bus.m_awburst <= bus.rq_awburst[w_gidx];
      end else if (r_state == ST_DATA && w_whs && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb_axi_write_arbiter: directed scenarios plus randomized traffic, checked
// against a burst-level reference model (phase, winner, beats remaining).
module tb_axi_write_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_write_arbiter_if #(.AW(32), .DW(64)) bus ();
`ifdef AXI_WARB_TIMEOUT_EN
  logic timeout_o;
`endif

  axi_write_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
`ifdef AXI_WARB_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  // reference model: phase 0 idle, 1 addr, 2 data, 3 resp
  int          mph;
  bit          mlast, mg, tmo_now;
  int          mbeats, mwd;
  logic [44:0] mdesc;
  bit          acc [2];
  int          gq[$], gc[$];
  // observed event counters
  int          obs_aw [2], obs_bhs [2];
  int          obs_wl_hold, obs_last_hs, obs_tmo;
  logic [1:0]  smp_bvalid;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    bus.rq_awvalid = '0; bus.rq_awaddr = '0; bus.rq_awlen = '0;
    bus.rq_awsize  = '0; bus.rq_awburst = '0;
    bus.rq_wvalid  = '0; bus.rq_wdata = '0; bus.rq_wstrb = '0;
    bus.rq_bready  = '0;
    bus.m_awready  = 1'b0; bus.m_wready = 1'b0;
    bus.m_bvalid   = 1'b0; bus.m_bresp = 2'b00;
  endtask

  task automatic model_reset();
    mph = 0; mlast = 1'b1; mg = 1'b0; mbeats = 0; mwd = 0; tmo_now = 1'b0;
    acc[0] = 1'b0; acc[1] = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_awready"}, bus.rq_awready, 0);
    chk({tag, "_awvalid"}, bus.m_awvalid, 0);
    chk({tag, "_awdesc"}, {bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst}, 0);
    chk({tag, "_wvalid"}, {bus.m_wvalid, bus.m_wlast, bus.rq_wready}, 0);
    chk({tag, "_wdata"}, bus.m_wdata, 0);
    chk({tag, "_bside"}, {bus.m_bready, bus.rq_bvalid, bus.rq_bresp}, 0);
`ifdef AXI_WARB_TIMEOUT_EN
    chk({tag, "_timeout"}, timeout_o, 0);
`endif
  endtask

  // compare DUT outputs with the model for this cycle, then advance the
  // model by the handshakes that the coming rising edge will complete
  task automatic check_step();
    logic [1:0] req, e;
    bit w;
    req = bus.rq_awvalid;
    smp_bvalid = bus.rq_bvalid;
`ifdef AXI_WARB_TIMEOUT_EN
    chk("timeout_o", timeout_o, tmo_now);
    if (timeout_o) obs_tmo++;
`endif
    tmo_now = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.rq_awready[i]) obs_aw[i]++;
      if (bus.rq_bvalid[i] && bus.rq_bready[i]) obs_bhs[i]++;
    end
    if (bus.m_wvalid && bus.m_wlast && !bus.m_wready) obs_wl_hold++;
    if (bus.m_wvalid && bus.m_wlast && bus.m_wready) obs_last_hs++;

    case (mph)
      0: begin
        e = '0;
        if (|req) begin
          w = (req == 2'b11) ? ~mlast : req[1];
          e[w] = 1'b1;
        end
        chk("awready", bus.rq_awready, e);
        if (|req) begin
          mg = w; mlast = w; acc[w] = 1'b1;
          mdesc = {bus.rq_awaddr[w], bus.rq_awlen[w], bus.rq_awsize[w], bus.rq_awburst[w]};
          mbeats = int'(bus.rq_awlen[w]) + 1;
          gq.push_back(int'(w)); gc.push_back(cyc);
          mph = 1;
        end
      end
      default: chk("awready_busy", bus.rq_awready, 0);
    endcase

    if (mph == 1 && !(|acc[0] || |acc[1] ) ) begin end
    if (mph == 1 && gc.size() > 0 && gc[$] != cyc) begin
      chk("m_awvalid", bus.m_awvalid, 1);
      chk("m_awdesc", {bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst}, mdesc);
      if (bus.m_awready) mph = 2;
    end else if (mph != 1) begin
      chk("m_awvalid_off", bus.m_awvalid, 0);
    end

    if (mph == 2 && gc[$] != cyc && !(bus.m_awvalid)) begin
      e = '0; e[mg] = bus.m_wready;
      chk("m_wvalid", bus.m_wvalid, bus.rq_wvalid[mg]);
      chk("rq_wready", bus.rq_wready, e);
      if (bus.rq_wvalid[mg]) begin
        chk("m_wdata", bus.m_wdata, bus.rq_wdata[mg]);
        chk("m_wstrb", bus.m_wstrb, bus.rq_wstrb[mg]);
        chk("m_wlast", bus.m_wlast, mbeats == 1);
        if (bus.m_wready) begin
          mbeats--;
          if (mbeats == 0) begin mph = 3; mwd = 0; end
        end
      end
    end else if (mph == 3 && !bus.m_wvalid) begin
`ifdef AXI_WARB_TIMEOUT_EN
      if (mwd >= 255) begin
        e = '0; e[mg] = 1'b1;
        chk("tmo_bvalid", bus.rq_bvalid, e);
        chk("tmo_bresp", bus.rq_bresp, 2'b10);
        chk("tmo_bready", bus.m_bready, 0);
        if (bus.rq_bready[mg]) begin mph = 0; tmo_now = 1'b1; end
      end else
`endif
      begin
        e = '0; e[mg] = bus.m_bvalid;
        chk("m_bready", bus.m_bready, bus.rq_bready[mg]);
        chk("rq_bvalid", bus.rq_bvalid, e);
        if (bus.m_bvalid) chk("rq_bresp", bus.rq_bresp, bus.m_bresp);
        if (bus.m_bvalid && bus.rq_bready[mg]) mph = 0;
        else if (!bus.m_bvalid) mwd++;
      end
    end else if (mph == 0 || mph == 1) begin
      chk("w_quiet", {bus.m_wvalid, bus.rq_wready}, 0);
      chk("b_quiet", {bus.m_bready, bus.rq_bvalid}, 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_step();
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (acc[i]) begin bus.rq_awvalid[i] = 1'b0; acc[i] = 1'b0; end
  endtask

  task automatic req(int i, int len);
    bus.rq_awvalid[i] = 1'b1;
    bus.rq_awaddr[i]  = 32'h1000 * (i + 1) + len;
    bus.rq_awlen[i]   = 8'(len);
    bus.rq_awsize[i]  = 3'd3;
    bus.rq_awburst[i] = 2'd1;
  endtask

  task automatic do_reset(string tag);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk_zero(tag);
    idle_inputs();
    model_reset();
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) begin
      if (!bus.rq_awvalid[i] && $urandom_range(0, 3) == 0) begin
        bus.rq_awvalid[i] = 1'b1;
        bus.rq_awaddr[i]  = $urandom;
        bus.rq_awlen[i]   = 8'($urandom_range(0, 7));
        bus.rq_awsize[i]  = 3'($urandom);
        bus.rq_awburst[i] = 2'($urandom);
      end
      bus.rq_wdata[i] = {$urandom, $urandom};
      bus.rq_wstrb[i] = 8'($urandom);
    end
    bus.rq_wvalid = 2'($urandom) | 2'($urandom);
    bus.rq_bready = 2'($urandom);
    bus.m_awready = ($urandom_range(0, 1) == 1);
    bus.m_wready  = ($urandom_range(0, 4) < 3);
    bus.m_bvalid  = ($urandom_range(0, 4) < 2);
    bus.m_bresp   = 2'($urandom);
  endtask

  initial begin
    int b0, l0, h0, n;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // lone requester 0, awlen 3, zero-wait slave
    l0 = obs_last_hs; b0 = obs_bhs[0];
    req(0, 3);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.rq_wvalid = 2'b11;
    bus.m_bvalid = 1'b1; bus.rq_bready = 2'b11;
    for (int k = 0; k < 8; k++) step();
    chk("t1_last_cnt", obs_last_hs - l0, 1);
    chk("t1_bdone", obs_bhs[0] - b0, 1);

    // simultaneous requests straight after reset
    do_reset("rst2");
    req(0, 0); req(1, 0);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.rq_wvalid = 2'b11;
    bus.m_bvalid = 1'b1; bus.rq_bready = 2'b11;
    for (int k = 0; k < 10; k++) step();
    chk("t2_first", gq[gq.size()-2], 0);
    chk("t2_second", gq[gq.size()-1], 1);
    chk("t2_gap", gc[gc.size()-1] - gc[gc.size()-2], 4);

    // single beat held by slave wait states, then stalled SLVERR response
    idle_inputs();
    h0 = obs_wl_hold; b0 = obs_bhs[1];
    req(1, 0);
    bus.m_awready = 1'b1; bus.rq_wvalid = 2'b10;
    step(); step();
    for (int k = 0; k < 5; k++) step();
    chk("t3_wlast_hold", obs_wl_hold - h0, 5);
    bus.m_wready = 1'b1;
    step();
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b10;
    for (int k = 0; k < 3; k++) step();
    chk("t4_no_bhs", obs_bhs[1] - b0, 0);
    bus.rq_bready = 2'b10;
    step(); step();
    chk("t4_bdone", obs_bhs[1] - b0, 1);

    // reset in the middle of an 8-beat burst
    idle_inputs();
    req(0, 7);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.rq_wvalid = 2'b01;
    for (int k = 0; k < 5; k++) step();
    do_reset("rst_mid");
    req(0, 0); req(1, 0);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.rq_wvalid = 2'b11;
    bus.m_bvalid = 1'b1; bus.rq_bready = 2'b11;
    step();
    chk("rst_prio", gq[gq.size()-1], 0);
    for (int k = 0; k < 10; k++) step();

    // randomized traffic
    idle_inputs();
    for (int i = 0; i < 2; i++) begin obs_aw[i] = 0; obs_bhs[i] = 0; end
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.rq_wvalid = 2'b11;
    bus.m_bvalid = 1'b1; bus.rq_bready = 2'b11;
    for (int k = 0; k < 100 && mph != 0; k++) step();
    step();
    chk("bal0", obs_bhs[0], obs_aw[0]);
    chk("bal1", obs_bhs[1], obs_aw[1]);
    chk("rand_both_used", (obs_aw[0] > 10) && (obs_aw[1] > 10), 1);

`ifdef AXI_WARB_TIMEOUT_EN
    idle_inputs();
    obs_tmo = 0;
    req(1, 0);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.rq_wvalid = 2'b10;
    step(); step(); step();
    n = 0;
    while (n < 400) begin
      step();
      if (smp_bvalid[1]) break;
      n++;
    end
    chk("tmo_wait", n, 255);
    step(); step();
    bus.rq_bready = 2'b10;
    step(); step(); step();
    chk("tmo_pulses", obs_tmo, 1);
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "bench time limit");
  end
endmodule
